// File: rtl/ttl_models_pkg.sv
// Shared definitions for the TTL chip-model library: default synchroniser
// depth and the preset/clear decode used by every flip-flop style model.
package ttl_models_pkg;

  localparam int DEFAULT_SYNC_STAGES = 2;

  // Combined state of the active-low preset (Sb) and clear (Rb) pins.
  typedef enum logic [1:0] {
    SR_NONE,
    SR_CLR,
    SR_SET,
    SR_BOTH
  } sr_state_t;

  // Map the two active-low pins onto a single priority state.
  function automatic sr_state_t sr_decode(input logic sb, input logic rb);
    sr_state_t st;
    if (!sb && !rb) begin
      st = SR_BOTH;
    end else if (!rb) begin
      st = SR_CLR;
    end else if (!sb) begin
      st = SR_SET;
    end else begin
      st = SR_NONE;
    end
    return st;
  endfunction

endpackage

// File: rtl/ttl_dff_chan.sv
// One flip-flop channel: input synchroniser, arming, chip-clock edge
// detect, preset/clear priority, toggle mode and capture strobe.
module ttl_dff_chan
  import ttl_models_pkg::*;
#(
  parameter int WIDTH       = 1,
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic             clk_i,
  input  logic             rstb_i,
  input  logic [WIDTH-1:0] d_i,
  input  logic             c_i,
  input  logic             sb_i,
  input  logic             rb_i,
  input  logic             tgl_i,
  output logic [WIDTH-1:0] q_o,
  output logic [WIDTH-1:0] qb_o,
  output logic             cap_o
);

  // All pins travel together so their relative timing is preserved.
  // vld marks stages holding a genuine post-reset sample, so the reset
  // fill value of C is never mistaken for a real low level when arming.
  typedef struct packed {
    logic             vld;
    logic             c;
    logic             sb;
    logic             rb;
    logic             tgl;
    logic [WIDTH-1:0] d;
  } sync_t;

  localparam sync_t SYNC_RST = '{vld: 1'b0, c: 1'b0, sb: 1'b1, rb: 1'b1,
                                 tgl: 1'b0, d: '0};

  sync_t            sync_in;
  sync_t            sync_q [SYNC_STAGES];
  sync_t            sync_s;

  logic             c_prev_q;
  logic             armed_q;
  logic             armed_d;
  logic             rise;
  sr_state_t        sr_st;

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic             both_q;
  logic             both_d;
  logic             cap_q;
  logic             cap_d;

  logic [WIDTH-1:0] q_out_q;
  logic [WIDTH-1:0] qb_out_q;
  logic             cap_out_q;

  assign sync_in = {1'b1, c_i, sb_i, rb_i, tgl_i, d_i};
  assign sync_s  = sync_q[SYNC_STAGES-1];

  // Shift the bundled pin samples through the synchroniser chain.
  always_ff @(posedge clk_i) begin
    if (!rstb_i) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= SYNC_RST;
      end
    end else begin
      sync_q[0] <= sync_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  // Arm only after a real low has been seen, so C held high across
  // reset cannot fake a rising edge.
  assign armed_d = armed_q | (sync_s.vld & ~sync_s.c);
  assign rise    = sync_s.c & ~c_prev_q & armed_q;
  assign sr_st   = sr_decode(sync_s.sb, sync_s.rb);

  // Next-state: preset/clear win over a capture; a masked edge is dropped.
  always_comb begin
    q_d    = q_q;
    both_d = 1'b0;
    cap_d  = 1'b0;
    case (sr_st)
      SR_BOTH: begin
        q_d    = '1;
        both_d = 1'b1;
      end
      SR_CLR:  q_d = '0;
      SR_SET:  q_d = '1;
      SR_NONE: begin
        if (rise) begin
          q_d   = sync_s.tgl ? ~q_q : sync_s.d;
          cap_d = 1'b1;
        end
      end
      default: q_d = q_q;
    endcase
  end

  // Flip-flop state, edge-detect history and arming.
  always_ff @(posedge clk_i) begin
    if (!rstb_i) begin
      q_q      <= '0;
      both_q   <= 1'b0;
      cap_q    <= 1'b0;
      c_prev_q <= 1'b0;
      armed_q  <= 1'b0;
    end else begin
      q_q      <= q_d;
      both_q   <= both_d;
      cap_q    <= cap_d;
      c_prev_q <= sync_s.c;
      armed_q  <= armed_d;
    end
  end

  // Registered outputs; Qb only departs from ~Q while both pins are low.
  always_ff @(posedge clk_i) begin
    if (!rstb_i) begin
      q_out_q   <= '0;
      qb_out_q  <= '1;
      cap_out_q <= 1'b0;
    end else begin
      q_out_q   <= q_q;
      qb_out_q  <= both_q ? '1 : ~q_q;
      cap_out_q <= cap_q;
    end
  end

  assign q_o   = q_out_q;
  assign qb_o  = qb_out_q;
  assign cap_o = cap_out_q;

endmodule

// File: rtl/ttl_dff_bank.sv
// Bank of independent D flip-flop channels; slices the packed buses and
// hands each channel to its own ttl_dff_chan instance.
module ttl_dff_bank
  import ttl_models_pkg::*;
#(
  parameter int CHANNELS    = 2,
  parameter int WIDTH       = 1,
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic                      CLK,
  input  logic                      RSTb,
  input  logic [CHANNELS*WIDTH-1:0] D,
  input  logic [CHANNELS-1:0]       C,
  input  logic [CHANNELS-1:0]       Sb,
  input  logic [CHANNELS-1:0]       Rb,
  input  logic [CHANNELS-1:0]       TGL,
  output logic [CHANNELS*WIDTH-1:0] Q,
  output logic [CHANNELS*WIDTH-1:0] Qb,
  output logic [CHANNELS-1:0]       CAP
);

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
    ttl_dff_chan #(
      .WIDTH       (WIDTH),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_chan (
      .clk_i  (CLK),
      .rstb_i (RSTb),
      .d_i    (D[gi*WIDTH +: WIDTH]),
      .c_i    (C[gi]),
      .sb_i   (Sb[gi]),
      .rb_i   (Rb[gi]),
      .tgl_i  (TGL[gi]),
      .q_o    (Q[gi*WIDTH +: WIDTH]),
      .qb_o   (Qb[gi*WIDTH +: WIDTH]),
      .cap_o  (CAP[gi])
    );
  end

endmodule

// File: tb/tb_ttl_dff_bank.sv
// Self-checking bench for ttl_dff_bank (2 channels x 4 bits, 2 sync stages).
module tb_ttl_dff_bank;

  localparam int CH = 2;
  localparam int W  = 4;
  localparam int SS = 2;

  logic            clk = 1'b0;
  logic            rstb;
  logic [CH*W-1:0] d;
  logic [CH-1:0]   c;
  logic [CH-1:0]   sb;
  logic [CH-1:0]   rb;
  logic [CH-1:0]   tgl;
  logic [CH*W-1:0] q;
  logic [CH*W-1:0] qb;
  logic [CH-1:0]   cap;

  always #5 clk = ~clk;

  ttl_dff_bank #(
    .CHANNELS    (CH),
    .WIDTH       (W),
    .SYNC_STAGES (SS)
  ) dut (
    .CLK  (clk),
    .RSTb (rstb),
    .D    (d),
    .C    (c),
    .Sb   (sb),
    .Rb   (rb),
    .TGL  (tgl),
    .Q    (q),
    .Qb   (qb),
    .CAP  (cap)
  );

  typedef struct {
    int         ch;
    logic [3:0] d;
    logic       tgl;
    logic       sb;
    logic       rb;
    logic       cp;
    logic [3:0] exp_q;
    logic [3:0] exp_qb;
    logic       exp_cap;
  } vec_t;

  typedef struct {
    int         ch;
    logic [3:0] q;
    logic [3:0] qb;
    logic       cap;
  } exp_t;

  localparam int NVEC = 20;
  vec_t       vecs [NVEC];
  exp_t       sbq [$];
  int         passed;
  int         total;
  int         cap_seen [CH];
  logic [3:0] prev_q  [CH];
  logic [3:0] prev_qb [CH];

  // Count CAP high cycles per channel.
  always @(negedge clk) begin
    for (int i = 0; i < CH; i++) begin
      if (rstb === 1'b1 && cap[i] === 1'b1) cap_seen[i]++;
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  function automatic logic [3:0] qch(input int ch);
    return q[ch*W +: W];
  endfunction

  function automatic logic [3:0] qbch(input int ch);
    return qb[ch*W +: W];
  endfunction

  task automatic apply(input int idx, input vec_t v);
    exp_t e;
    int   oth;
    int   cap0;
    oth = 1 - v.ch;
    d[v.ch*W +: W] = v.d;
    tgl[v.ch] = v.tgl;
    sb[v.ch]  = v.sb;
    rb[v.ch]  = v.rb;
    c[v.ch]   = v.cp;
    sbq.push_back('{v.ch, v.exp_q, v.exp_qb, v.exp_cap});
    cap0 = cap_seen[v.ch];
    repeat (3) @(negedge clk);
    chk($sformatf("v%0d_early_q", idx), {4'h0, qch(v.ch)}, {4'h0, prev_q[v.ch]});
    chk($sformatf("v%0d_early_qb", idx), {4'h0, qbch(v.ch)}, {4'h0, prev_qb[v.ch]});
    chk($sformatf("v%0d_early_cap", idx), {7'h0, cap[v.ch]}, 8'h0);
    @(negedge clk);
    e = sbq.pop_front();
    chk($sformatf("v%0d_q", idx), {4'h0, qch(e.ch)}, {4'h0, e.q});
    chk($sformatf("v%0d_qb", idx), {4'h0, qbch(e.ch)}, {4'h0, e.qb});
    chk($sformatf("v%0d_cap", idx), {7'h0, cap[e.ch]}, {7'h0, e.cap});
    chk($sformatf("v%0d_other_q", idx), {4'h0, qch(oth)}, {4'h0, prev_q[oth]});
    $display("vec %0d ch%0d d=%h tgl=%b sb=%b rb=%b c=%b -> q=%h qb=%h cap=%b",
             idx, v.ch, v.d, v.tgl, v.sb, v.rb, v.cp, qch(e.ch), qbch(e.ch), cap[e.ch]);
    c[v.ch] = 1'b0;
    @(negedge clk);
    chk($sformatf("v%0d_cap_one_cycle", idx), {7'h0, cap[e.ch]}, 8'h0);
    chk($sformatf("v%0d_cap_count", idx), 8'(cap_seen[e.ch] - cap0), {7'h0, e.cap});
    prev_q[e.ch]  = e.q;
    prev_qb[e.ch] = e.qb;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cap0;
    passed = 0;
    total  = 0;
    for (int i = 0; i < CH; i++) cap_seen[i] = 0;
    rstb = 1'b0;
    d    = '0;
    c    = '0;
    sb   = '1;
    rb   = '1;
    tgl  = '0;

    // fields: ch, d, tgl, sb, rb, C pulse, expected Q, Qb, CAP
    vecs[0]  = '{0, 4'hA, 1'b0, 1'b1, 1'b1, 1'b1, 4'hA, 4'h5, 1'b1};
    vecs[1]  = '{1, 4'h0, 1'b1, 1'b1, 1'b1, 1'b1, 4'hF, 4'h0, 1'b1};
    vecs[2]  = '{1, 4'h0, 1'b1, 1'b1, 1'b1, 1'b1, 4'h0, 4'hF, 1'b1};
    vecs[3]  = '{1, 4'h0, 1'b1, 1'b1, 1'b1, 1'b1, 4'hF, 4'h0, 1'b1};
    vecs[4]  = '{1, 4'h0, 1'b1, 1'b1, 1'b1, 1'b1, 4'h0, 4'hF, 1'b1};
    vecs[5]  = '{0, 4'hA, 1'b0, 1'b0, 1'b0, 1'b0, 4'hF, 4'hF, 1'b0};
    vecs[6]  = '{0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 4'hF, 4'hF, 1'b0};
    vecs[7]  = '{0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 4'hF, 4'h0, 1'b0};
    vecs[8]  = '{0, 4'h7, 1'b0, 1'b1, 1'b0, 1'b1, 4'h0, 4'hF, 1'b0};
    vecs[9]  = '{0, 4'h7, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 4'hF, 1'b0};
    vecs[10] = '{0, 4'h7, 1'b0, 1'b1, 1'b1, 1'b1, 4'h7, 4'h8, 1'b1};
    vecs[11] = '{0, 4'h7, 1'b0, 1'b0, 1'b1, 1'b0, 4'hF, 4'h0, 1'b0};
    vecs[12] = '{0, 4'h7, 1'b0, 1'b1, 1'b1, 1'b0, 4'hF, 4'h0, 1'b0};
    vecs[13] = '{0, 4'hC, 1'b1, 1'b1, 1'b1, 1'b1, 4'h0, 4'hF, 1'b1};
    vecs[14] = '{0, 4'h5, 1'b0, 1'b1, 1'b1, 1'b1, 4'h5, 4'hA, 1'b1};
    vecs[15] = '{0, 4'h5, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'hF, 1'b0};
    vecs[16] = '{0, 4'h5, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 4'hF, 1'b0};
    vecs[17] = '{0, 4'h5, 1'b0, 1'b0, 1'b0, 1'b0, 4'hF, 4'hF, 1'b0};
    vecs[18] = '{0, 4'h5, 1'b0, 1'b0, 1'b1, 1'b0, 4'hF, 4'h0, 1'b0};
    vecs[19] = '{0, 4'h5, 1'b0, 1'b1, 1'b1, 1'b0, 4'hF, 4'h0, 1'b0};

    // Reset state
    repeat (4) @(negedge clk);
    chk("reset_q", q, 8'h00);
    chk("reset_qb", qb, 8'hFF);
    chk("reset_cap", {6'h0, cap}, 8'h00);
    $display("reset q=%h qb=%h cap=%b", q, qb, cap);
    rstb = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < CH; i++) begin
      prev_q[i]  = 4'h0;
      prev_qb[i] = 4'hF;
    end

    for (int i = 0; i < NVEC; i++) apply(i, vecs[i]);

    // Exact latency; D changing after the sampling edge must not matter.
    d[3:0] = 4'h9;
    c[0]   = 1'b1;
    @(negedge clk);
    d[3:0] = 4'h1;
    repeat (2) @(negedge clk);
    chk("lat_early_q", {4'h0, qch(0)}, 8'h0F);
    @(negedge clk);
    chk("lat_q", {4'h0, qch(0)}, 8'h09);
    chk("lat_qb", {4'h0, qbch(0)}, 8'h06);
    chk("lat_cap", {7'h0, cap[0]}, 8'h01);
    $display("latency seq q0=%h qb0=%h cap0=%b", qch(0), qbch(0), cap[0]);
    c[0] = 1'b0;
    repeat (4) @(negedge clk);

    // C held high across reset release: no capture until a fresh low->high.
    c[0] = 1'b1;
    rstb = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst2_q", q, 8'h00);
    chk("rst2_qb", qb, 8'hFF);
    rstb = 1'b1;
    cap0 = cap_seen[0];
    repeat (6) @(negedge clk);
    chk("chigh_q", {4'h0, qch(0)}, 8'h00);
    chk("chigh_cap_count", 8'(cap_seen[0] - cap0), 8'h00);
    $display("c-high-reset seq q0=%h caps=%0d", qch(0), cap_seen[0] - cap0);
    c[0] = 1'b0;
    repeat (3) @(negedge clk);
    d[3:0] = 4'h3;
    c[0]   = 1'b1;
    repeat (4) @(negedge clk);
    chk("rearm_q", {4'h0, qch(0)}, 8'h03);
    chk("rearm_qb", {4'h0, qbch(0)}, 8'h0C);
    chk("rearm_cap", {7'h0, cap[0]}, 8'h01);
    $display("rearm seq q0=%h qb0=%h cap0=%b", qch(0), qbch(0), cap[0]);
    c[0] = 1'b0;
    repeat (4) @(negedge clk);

    // Reset one cycle after a rise: the in-flight capture is lost.
    d[3:0] = 4'hE;
    c[0]   = 1'b1;
    cap0   = cap_seen[0];
    @(negedge clk);
    rstb = 1'b0;
    @(negedge clk);
    rstb = 1'b1;
    repeat (8) @(negedge clk);
    chk("abort_q", {4'h0, qch(0)}, 8'h00);
    chk("abort_qb", {4'h0, qbch(0)}, 8'h0F);
    chk("abort_cap_count", 8'(cap_seen[0] - cap0), 8'h00);
    $display("abort seq q0=%h qb0=%h caps=%0d", qch(0), qbch(0), cap_seen[0] - cap0);
    c[0] = 1'b0;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
